// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - processor memory bus and console stream bundle
interface mem_bus_responder_if;
  logic [31:0] Mem_Address;
  logic        Mem_WriteEnable;
  logic [31:0] Mem_DataOut;
  logic [31:0] Mem_DataIn;
  logic [7:0]  Con_Data;
  logic        Con_Valid;
  logic        Con_Ready;
  logic        Halted;
  logic [31:0] CycleCount;

  modport master (
    output Mem_Address, Mem_WriteEnable, Mem_DataOut, Con_Ready,
    input  Mem_DataIn, Con_Data, Con_Valid, Halted, CycleCount
  );

  modport slave (
    input  Mem_Address, Mem_WriteEnable, Mem_DataOut, Con_Ready,
    output Mem_DataIn, Con_Data, Con_Valid, Halted, CycleCount
  );
endinterface

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - zero-wait RAM plus console FIFO, cycle counter and halt MMIO
module mem_bus_responder #(
  parameter int RamWords  = 4032,
  parameter int FifoDepth = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  mem_bus_responder_if.slave bus
);
  localparam int RamAw = $clog2(RamWords);
  localparam int PtrW  = $clog2(FifoDepth);
  localparam logic [13:0] ConAddr  = 14'hFC0;
  localparam logic [13:0] CycAddr  = 14'hFC1;
  localparam logic [13:0] HaltAddr = 14'hFFF;

  logic [31:0]     r_ram  [RamWords];
  logic [7:0]      r_fifo [FifoDepth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [PtrW:0]   r_count;
  logic            r_ovf;
  logic            r_halted;
  logic [31:0]     r_cycle;

  logic [13:0]      w_word;
  logic [RamAw-1:0] w_ram_idx;
  logic             w_is_ram;
  logic             w_wr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_con_wr;
  logic             w_push;
  logic [31:0]      w_rdata;

  assign w_word    = bus.Mem_Address[15:2];
  assign w_ram_idx = w_word[RamAw-1:0];
  assign w_is_ram  = w_word < 14'(RamWords);
  assign w_wr      = bus.Mem_WriteEnable && !r_halted;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (PtrW+1)'(FifoDepth));
  assign w_pop     = !w_empty && bus.Con_Ready;
  assign w_con_wr  = w_wr && !w_is_ram && (w_word == ConAddr);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push    = w_con_wr && (!w_full || w_pop);

  always_comb begin
    w_rdata = 32'h0;
    if (w_is_ram) begin
      w_rdata = r_ram[w_ram_idx];
    end else begin
      case (w_word)
        ConAddr:  w_rdata = {29'b0, r_ovf, w_full, w_empty};
        CycAddr:  w_rdata = r_cycle;
        HaltAddr: w_rdata = {31'b0, r_halted};
        default:  w_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (w_wr && w_is_ram) r_ram[w_ram_idx] <= bus.Mem_DataOut;
    if (w_push) r_fifo[r_wptr] <= bus.Mem_DataOut[7:0];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_halted <= 1'b0;
      r_cycle  <= 32'h0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_con_wr && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_wr && !w_is_ram && (w_word == CycAddr)) r_cycle <= bus.Mem_DataOut;
      else if (!r_halted) r_cycle <= r_cycle + 32'd1;
      if (w_wr && !w_is_ram && (w_word == HaltAddr)) r_halted <= 1'b1;
    end
  end

  assign bus.Mem_DataIn = w_rdata;
  assign bus.Con_Valid  = !w_empty;
  assign bus.Con_Data   = w_empty ? 8'h00 : r_fifo[r_rptr];
  assign bus.Halted     = r_halted;
  assign bus.CycleCount = r_cycle;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed bench with a queue-based reference model
module tb_mem_bus_responder;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  mem_bus_responder_if bus();

  mem_bus_responder #(.RamWords(4032), .FifoDepth(8)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit running  = 1'b0;

  logic [31:0] m_mem [int];
  logic [7:0]  m_q [$];
  logic [31:0] m_cnt  = 32'h0;
  bit          m_halt = 1'b0;
  bit          m_ovf  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] addr, output bit known);
    int a = int'(addr[15:2]);
    known = 1'b1;
    if (a < 'hFC0) begin
      known = m_mem.exists(a);
      return known ? m_mem[a] : 32'h0;
    end
    case (a)
      'hFC0:   return {29'b0, m_ovf, m_q.size() == 8, m_q.size() == 0};
      'hFC1:   return m_cnt;
      'hFFF:   return {31'b0, m_halt};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step();
    int a    = int'(bus.Mem_Address[15:2]);
    bit full = (m_q.size() == 8);
    bit pop  = (m_q.size() != 0) && bus.Con_Ready;
    bit wr   = bus.Mem_WriteEnable && !m_halt;
    if (pop) void'(m_q.pop_front());
    if (wr && a < 'hFC0) m_mem[a] = bus.Mem_DataOut;
    if (wr && a == 'hFC0) begin
      if (!full || pop) m_q.push_back(bus.Mem_DataOut[7:0]);
      else m_ovf = 1'b1;
    end
    if (wr && a == 'hFC1) m_cnt = bus.Mem_DataOut;
    else if (!m_halt) m_cnt = m_cnt + 32'd1;
    if (wr && a == 'hFFF) m_halt = 1'b1;
  endtask

  task automatic m_reset();
    m_q.delete();
    m_cnt  = 32'h0;
    m_halt = 1'b0;
    m_ovf  = 1'b0;
  endtask

  always @(negedge Clock) begin : compare
    logic [31:0] e;
    bit k;
    if (running && !Reset) begin
      chk("con_valid", bus.Con_Valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("con_data", bus.Con_Data, m_q[0]);
      chk("halted", bus.Halted, m_halt);
      chk("cycle_count", bus.CycleCount, m_cnt);
      e = m_read(bus.Mem_Address, k);
      if (k) chk("mem_datain", bus.Mem_DataIn, e);
    end
  end

  task automatic drive(input logic [31:0] addr, input logic we, input logic [31:0] data);
    bus.Mem_Address     = addr;
    bus.Mem_WriteEnable = we;
    bus.Mem_DataOut     = data;
  endtask

  task automatic tick();
    @(negedge Clock);
    #1;
    m_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic peek(input string name, input logic [31:0] addr, input logic [31:0] exp);
    drive(addr, 1'b0, 32'h0);
    #1;
    chk(name, bus.Mem_DataIn, exp);
  endtask

  logic [7:0] got [$];
  logic [31:0] saved;

  initial begin
    drive(32'h0, 1'b0, 32'h0);
    bus.Con_Ready = 1'b0;
    #1;
    chk("rst_valid", bus.Con_Valid, 1'b0);
    chk("rst_data", bus.Con_Data, 8'h00);
    chk("rst_halted", bus.Halted, 1'b0);
    chk("rst_cycle", bus.CycleCount, 32'h0);
    @(posedge Clock);
    #1;
    Reset   = 1'b0;
    running = 1'b1;
    tick();
    chk("first_count", bus.CycleCount, 32'h1);

    drive(32'h0000_0100, 1'b1, 32'hDEADBEEF);
    tick();
    peek("raw_0100", 32'h0000_0100, 32'hDEADBEEF);
    peek("raw_0103", 32'h0000_0103, 32'hDEADBEEF);
    drive(32'hABCD_0200, 1'b1, 32'h1122_3344);
    tick();
    peek("hi_bits_ignored", 32'h0000_0200, 32'h1122_3344);
    drive(32'h0000_3EFC, 1'b1, 32'hCAFE_F00D);
    tick();
    peek("last_ram_word", 32'h0000_3EFC, 32'hCAFE_F00D);
    drive(32'h0000_3F08, 1'b1, 32'h5555_AAAA);
    tick();
    peek("unmapped_3f08", 32'h0000_3F08, 32'h0);
    peek("unmapped_3ff8", 32'h0000_3FF8, 32'h0);

    for (int i = 0; i < 8; i++) begin
      drive(32'h0000_3F00, 1'b1, 32'h41 + i);
      tick();
    end
    peek("status_full", 32'h0000_3F00, 32'h2);
    drive(32'h0000_3F00, 1'b1, 32'h49);
    tick();
    peek("status_ovf_full", 32'h0000_3F00, 32'h6);
    bus.Con_Ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.Con_Valid) got.push_back(bus.Con_Data);
      tick();
    end
    chk("drain_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("drain_order", got[i], 8'h41 + i);
    peek("status_ovf_empty", 32'h0000_3F00, 32'h5);

    bus.Con_Ready = 1'b0;
    drive(32'h0000_3F00, 1'b1, 32'h50);
    tick();
    bus.Con_Ready = 1'b1;
    drive(32'h0000_3F00, 1'b1, 32'h51);
    tick();
    chk("push_pop_head", bus.Con_Data, 8'h51);
    bus.Con_Ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(32'h0000_3F00, 1'b1, 32'h60 + i);
      tick();
    end
    bus.Con_Ready = 1'b1;
    drive(32'h0000_3F00, 1'b1, 32'h70);
    tick();
    chk("full_pop_head", bus.Con_Data, 8'h60);
    bus.Con_Ready = 1'b0;
    peek("full_pop_status", 32'h0000_3F00, 32'h6);
    bus.Con_Ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("drained", bus.Con_Valid, 1'b0);

    drive(32'h0000_3F04, 1'b1, 32'hFFFF_FFFE);
    tick();
    chk("cycle_load", bus.CycleCount, 32'hFFFF_FFFE);
    drive(32'h0000_3F04, 1'b0, 32'h0);
    tick();
    chk("cycle_max", bus.CycleCount, 32'hFFFF_FFFF);
    tick();
    chk("cycle_wrap", bus.CycleCount, 32'h0);

    bus.Con_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_3F00, 1'b1, 32'h31 + i);
      tick();
    end
    drive(32'h0000_3FFC, 1'b1, 32'h1);
    #2;
    Reset = 1'b1;
    m_reset();
    #1;
    chk("async_valid", bus.Con_Valid, 1'b0);
    chk("async_cycle", bus.CycleCount, 32'h0);
    chk("async_halted", bus.Halted, 1'b0);
    @(posedge Clock);
    #1;
    chk("halt_in_reset", bus.Halted, 1'b0);
    drive(32'h0000_0100, 1'b0, 32'h0);
    Reset = 1'b0;
    tick();
    chk("resume_count", bus.CycleCount, 32'h1);
    peek("ram_survives", 32'h0000_0100, 32'hDEADBEEF);

    for (int i = 0; i < 2; i++) begin
      drive(32'h0000_3F00, 1'b1, 32'h21 + i);
      tick();
    end
    drive(32'h0000_3FFC, 1'b1, 32'h0);
    tick();
    chk("halt_set", bus.Halted, 1'b1);
    peek("halt_read", 32'h0000_3FFC, 32'h1);
    saved = m_cnt;
    drive(32'h0000_0100, 1'b1, 32'h1234);
    tick();
    drive(32'h0000_3F04, 1'b1, 32'h0);
    tick();
    drive(32'h0000_3F00, 1'b1, 32'h99);
    tick();
    chk("cycle_frozen", bus.CycleCount, saved);
    peek("halt_ram_kept", 32'h0000_0100, 32'hDEADBEEF);
    peek("halt_status", 32'h0000_3F00, 32'h0);
    bus.Con_Ready = 1'b1;
    chk("halt_head", bus.Con_Data, 8'h21);
    tick();
    tick();
    chk("halt_drained", bus.Con_Valid, 1'b0);

    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 The module SHALL have one clock, Clock; reset is asynchronous and active-high, named Reset.
REQ-002 Parameter RamWords, default 4032: number of 32-bit RAM words, covering byte addresses 0x0000-0x3EFF.
REQ-003 Parameter FifoDepth, default 8: console FIFO entries, power of two.
REQ-004 Clock  in  1  rising-edge clock for all state.
REQ-005 Reset  in  1  asynchronous, active-high; clears all registers except RAM contents.
REQ-006 Mem_Address  in  32  byte address from the processor; bits [1:0] and [31:16] are ignored.
REQ-007 Mem_WriteEnable  in  1  write strobe, sampled on the rising edge of Clock.
REQ-008 Mem_DataOut  in  32  store data from the processor.
REQ-009 Mem_DataIn  out  32  load data to the processor, combinational from Mem_Address.
REQ-010 Con_Data  out  8  console byte at the FIFO head.
REQ-011 Con_Valid  out  1  FIFO not empty.
REQ-012 Con_Ready  in  1  console sink accepts Con_Data.
REQ-013 Halted  out  1  sticky halt flag.
REQ-014 CycleCount  out  32  free-running cycle counter.

Function
REQ-015 Decode uses A = Mem_Address[15:2]: RAM when A < 0xFC0 (byte address < 0x3F00); MMIO otherwise.
REQ-016 RAM read: Mem_DataIn = RAM[A] combinationally in the same cycle, with zero wait states.
REQ-017 RAM write: RAM[A] <= Mem_DataOut on the rising edge when Mem_WriteEnable=1, A is in the RAM range, and Halted=0.
REQ-018 A read-after-write to the same RAM word in the next cycle SHALL return the new data.
REQ-019 The MMIO map SHALL be:
- 0x3F00 CONSOLE: write pushes Mem_DataOut[7:0]; read returns {29'b0, Overflow, Full, Empty}.
- 0x3F04 CYCLE: read returns CycleCount; write loads Mem_DataOut.
- 0x3FFC HALT: a write of any value sets Halted; a read returns {31'b0, Halted}.
REQ-020 Any other MMIO address SHALL read 0x00000000, and writes to it SHALL be ignored.
REQ-021 FIFO push SHALL occur on a CONSOLE write when not full, or when full with a pop in the same cycle.
REQ-022 A push while full with no pop SHALL drop the byte and set sticky Overflow, which is cleared only by Reset.
REQ-023 FIFO pop SHALL occur when Con_Valid && Con_Ready; Con_Data is the head byte.
REQ-024 There is no bypass: a byte pushed into an empty FIFO appears on Con_Valid/Con_Data the next cycle.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged, with order preserved.
REQ-026 Read/write pointers SHALL wrap modulo FifoDepth.
REQ-027 CycleCount SHALL increment by 1 each cycle while Halted=0, wrapping 0xFFFFFFFF -> 0.
REQ-028 A CYCLE write SHALL take priority over the increment.
REQ-029 While Halted=1, CycleCount SHALL freeze, and all writes (RAM, CONSOLE, CYCLE) SHALL be ignored.
REQ-030 While Halted=1, reads and FIFO pops SHALL continue, so the console drains.
REQ-031 The halting write itself SHALL still count as a write: Halted=1 from the next edge.

Reset
REQ-032 On Reset=1, asynchronously: Halted=0, CycleCount=0, FIFO empty (Con_Valid=0, Con_Data=0x00), Overflow=0.
REQ-033 RAM contents are not reset.
REQ-034 Reset asserted mid-operation SHALL discard FIFO contents and any same-cycle write to the MMIO registers.
REQ-035 In the first edge after Reset deasserts, the module SHALL resume normal counting and decode.

Verification
REQ-036 Write 0xDEADBEEF to 0x0100, then read 0x0100 the next cycle -> Mem_DataIn=0xDEADBEEF; read 0x0103 -> same word.
REQ-037 Write bytes 0x41..0x48 to 0x3F00 with Con_Ready=0 -> status reads 0x2 (Full).
REQ-038 Continue REQ-037 with a 9th write, 0x49 -> dropped, status 0x6; raise Con_Ready -> bytes 0x41..0x48 appear in order, then status 0x5.
REQ-039 Write 0xFFFFFFFE to 0x3F04 -> CycleCount shows 0xFFFFFFFF, then 0x00000000, on the following edges.
REQ-040 Write 1 to 0x3FFC -> Halted=1 next edge; CycleCount frozen; later write 0x1234 to 0x0100 -> RAM unchanged.
REQ-041 Assert Reset asynchronously mid-stream with 3 bytes queued -> Con_Valid=0, CycleCount=0, and Halted=0 immediately, without waiting for a clock edge.
